// File: rtl/temp_sensor_spi_reader.sv
// temp_sensor_spi_reader: polls a mode-0 SPI temperature sensor and holds the rounded,
// saturated whole-degree reading for the BCD seven-segment decoder.
module temp_sensor_spi_reader #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000000,
    parameter int unsigned FRAME_BITS    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       miso,
    output logic       sclk,
    output logic       cs_n,
    output logic [7:0] temp,
    output logic       temp_valid,
    output logic       neg,
    output logic       busy
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int HW = $clog2(2 * FRAME_BITS);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DW-1:0]           div_q, div_d;
    logic [HW-1:0]           half_q, half_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic [31:0]             tmr_q, tmr_d;
    logic [7:0]              temp_q, temp_d;
    logic                    sclk_q, sclk_d, cs_n_q, cs_n_d, neg_q, neg_d, valid_q, valid_d;
    logic                    tick, div_last, half_last;
    logic [8:0]              sum;

    assign tick      = (SAMPLE_PERIOD != 0) && (tmr_q == 32'(SAMPLE_PERIOD - 1));
    assign div_last  = div_q == DW'(CLK_DIV - 1);
    assign half_last = half_q == HW'(2 * FRAME_BITS - 1);
    // frame: sign, 8 integer bits, half-degree bit, 6 ignored bits
    assign sum       = {1'b0, sr_q[FRAME_BITS-2 -: 8]} + 9'(sr_q[FRAME_BITS-10]);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        half_d  = half_q;
        sr_d    = sr_q;
        sclk_d  = sclk_q;
        temp_d  = temp_q;
        neg_d   = neg_q;
        valid_d = 1'b0;
        tmr_d   = (SAMPLE_PERIOD == 0 || tick) ? '0 : tmr_q + 32'd1;
        case (state_q)
            IDLE: if (start || tick) begin
                state_d = SETUP;
                div_d   = '0;
                sr_d    = '0;
            end
            SETUP: begin
                div_d = div_last ? '0 : div_q + 1'b1;
                if (div_last) begin
                    state_d = SHIFT;
                    half_d  = '0;
                end
            end
            SHIFT: begin
                div_d = div_last ? '0 : div_q + 1'b1;
                if (div_last) begin
                    half_d = half_q + 1'b1;
                    sclk_d = ~sclk_q;
                    sr_d   = sclk_q ? sr_q : {sr_q[FRAME_BITS-2:0], miso};
                    if (half_last) begin
                        state_d = DONE;
                        sclk_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b1;
                neg_d   = sr_q[FRAME_BITS-1];
                temp_d  = sr_q[FRAME_BITS-1] ? 8'd0 : sum[8] ? 8'hFF : sum[7:0];
            end
        endcase
        cs_n_d = !(state_d == SETUP || state_d == SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            half_q  <= '0;
            sr_q    <= '0;
            tmr_q   <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            temp_q  <= '0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            sr_q    <= sr_d;
            tmr_q   <= tmr_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            temp_q  <= temp_d;
            neg_q   <= neg_d;
            valid_q <= valid_d;
        end
    end

    assign sclk       = sclk_q;
    assign cs_n       = cs_n_q;
    assign temp       = temp_q;
    assign neg        = neg_q;
    assign temp_valid = valid_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_temp_sensor_spi_reader.sv
// tb_temp_sensor_spi_reader: randomized frames against a decode model, plus reset,
// start-while-busy and auto-trigger checks.
module tb_temp_sensor_spi_reader;
    localparam int D = 4;

    logic        clk = 0, rst = 1, start = 0;
    logic [15:0] frm0 = 0, frm1 = 0;
    int          rises0 = 0, rises1 = 0, vcnt = 0;
    int          checks = 0, errors = 0;
    logic        miso0, sclk0, cs_n0, tv0, neg0, busy0;
    logic        miso1, sclk1, cs_n1, tv1, neg1, busy1;
    logic [7:0]  temp0, temp1;

    always #5 clk = ~clk;

    temp_sensor_spi_reader #(.CLK_DIV(D), .SAMPLE_PERIOD(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .miso(miso0), .sclk(sclk0), .cs_n(cs_n0),
        .temp(temp0), .temp_valid(tv0), .neg(neg0), .busy(busy0));

    temp_sensor_spi_reader #(.CLK_DIV(D), .SAMPLE_PERIOD(200)) dut1 (
        .clk(clk), .rst(rst), .start(1'b0), .miso(miso1), .sclk(sclk1), .cs_n(cs_n1),
        .temp(temp1), .temp_valid(tv1), .neg(neg1), .busy(busy1));

    // sensor model: bit index advances on every sclk rise, restarts when cs_n falls
    always @(negedge cs_n0 or posedge sclk0) rises0 <= sclk0 ? rises0 + 1 : 0;
    always @(negedge cs_n1 or posedge sclk1) rises1 <= sclk1 ? rises1 + 1 : 0;
    assign miso0 = (rises0 < 16) ? frm0[4'(15 - rises0)] : 1'b0;
    assign miso1 = (rises1 < 16) ? frm1[4'(15 - rises1)] : 1'b0;
    always @(posedge clk) if (tv0) vcnt <= vcnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [15:0] f);
        int s;
        if (f[15]) return {1'b1, 8'd0};
        s = int'(f >> 7) % 256 + int'(f >> 6) % 2;
        return {1'b0, 8'(s > 255 ? 255 : s)};
    endfunction

    task automatic xfer(input logic [15:0] f, input bit inj, input int idle);
        int cyc = 0, v0 = vcnt, hi = 0;
        bit got = 0, did = 0;
        frm0 = f;
        @(negedge clk) start = 1;
        @(posedge clk); #1 start = 0;
        check("cs_fall", 32'(cs_n0), 0);
        check("busy_on", 32'(busy0), 1);
        while (!got && cyc < 1000) begin
            @(posedge clk); #1 cyc++;
            if (inj) start = (rises0 == 5 && !did) || cyc == 33 * D;
            if (rises0 == 5) did = 1;
            got = tv0;
        end
        start = 0;
        check("latency", 32'(cyc), 32'(33 * D + 1));
        check("rises", 32'(rises0), 16);
        check("temp_neg", {23'd0, neg0, temp0}, {23'd0, model(f)});
        @(posedge clk); #1;
        check("pulse_w", 32'(tv0), 0);
        repeat (idle) begin
            @(posedge clk); #1 hi += busy0;
        end
        check("idle_busy", 32'(hi), 0);
        check("one_valid", 32'(vcnt - v0), 1);
        check("hold", {23'd0, neg0, temp0}, {23'd0, model(f)});
    endtask

    initial begin
        int cyc, hi;
        int t[$];
        repeat (3) @(posedge clk); #1;
        check("rst_state", {26'd0, cs_n0, sclk0, busy0, tv0, neg0, temp0 != 0}, 32'b100000);
        @(negedge clk) rst = 0;
        // reset mid-frame at bit 7
        frm0 = 16'(($urandom));
        @(negedge clk) start = 1;
        @(posedge clk); #1 start = 0;
        cyc = 0;
        while (rises0 != 7 && cyc < 1000) begin
            @(posedge clk); #1 cyc++;
        end
        check("reach_bit7", 32'(rises0), 7);
        rst = 1; #1;
        check("rst_async", {29'd0, cs_n0, sclk0, busy0}, 32'b100);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 0;
        check("rst_temp", 32'(temp0), 0);
        check("rst_novalid", 32'(vcnt), 0);
        // directed frames
        xfer(16'h0C80, 0, 5);
        xfer(16'h0CC0, 0, 5);
        xfer(16'h7FC0, 0, 5);
        xfer(16'hF380, 0, 5);
        xfer(16'h0500, 0, 5);
        xfer(16'h0A00, 1, 300);
        for (int i = 0; i < 12; i++) xfer(16'($urandom), ($urandom % 4) == 0, 1 + $urandom % 20);
        // no start, no timer: stays idle
        hi = 0; cyc = vcnt;
        repeat (300) begin
            @(posedge clk); #1 hi += busy0;
        end
        check("sp0_idle", 32'(hi), 0);
        check("sp0_novalid", 32'(vcnt - cyc), 0);
        // auto trigger every 200 cycles
        frm1 = 16'($urandom) & 16'h7FFF;
        @(negedge clk) rst = 1;
        @(negedge clk) rst = 0;
        for (int c = 1; c <= 800; c++) begin
            @(posedge clk); #1;
            if (tv1) t.push_back(c);
        end
        check("auto_n", 32'(t.size()), 3);
        if (t.size() >= 1) check("auto_first", 32'(t[0]), 32'(200 + 33 * D + 1));
        for (int i = 1; i < t.size(); i++) check("auto_period", 32'(t[i] - t[i-1]), 200);
        check("auto_temp", {23'd0, neg1, temp1}, {23'd0, model(frm1)});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
